// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: lane geometry, padding bytes, absorb FSM states
// and the lane slicing helper used by the absorb front end and round modules.
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = LANE_W * NUM_LANES;
    localparam int SEL_W     = $clog2(STATE_W);

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ABSORB    = 3'd1,
        PERM_REQ  = 3'd2,
        PERM_WAIT = 3'd3,
        PAD       = 3'd4,
        DONE      = 3'd5
    } absorb_state_t;

    // Bit offset of lane i inside the flat 1600-bit state: lane i = [64i +: 64].
    function automatic logic [SEL_W-1:0] lane_lo(input logic [4:0] i);
        return SEL_W'(i) * SEL_W'(LANE_W);
    endfunction

endpackage

// File: rtl/sha3_absorb_if.sv
// Message stream, permutation handshake and result bundle of the absorb block.
// The slave side is the absorb engine; the master side is its environment
// (message source, permutation core and squeeze consumer).
interface sha3_absorb_if;
    import sha3_pkg::*;

    logic               start;
    logic [LANE_W-1:0]  msg_data;
    logic               msg_valid;
    logic               msg_last;
    logic [3:0]         msg_bytes;
    logic               msg_ready;

    logic               perm_start;
    logic [STATE_W-1:0] perm_state_out;
    logic               perm_done;
    logic [STATE_W-1:0] perm_state_in;

    logic [STATE_W-1:0] state_out;
    logic               absorb_done;
    logic               busy;

    modport master (
        output start, msg_data, msg_valid, msg_last, msg_bytes,
        output perm_done, perm_state_in,
        input  msg_ready, perm_start, perm_state_out,
        input  state_out, absorb_done, busy
    );

    modport slave (
        input  start, msg_data, msg_valid, msg_last, msg_bytes,
        input  perm_done, perm_state_in,
        output msg_ready, perm_start, perm_state_out,
        output state_out, absorb_done, busy
    );

endinterface

// File: rtl/sha3_byte_mask.sv
// Byte-lane helpers for the final message word: a keep-mask that zeroes bytes
// at or beyond the valid byte count, and the domain pad byte positioned at
// the requested byte of a lane.
module sha3_byte_mask
    import sha3_pkg::*;
#(
    parameter logic [7:0] DOMAIN_PAD = PAD_DOMAIN
) (
    input  logic [3:0]        msg_bytes,
    input  logic [2:0]        pad_byte,
    output logic [LANE_W-1:0] keep_mask,
    output logic [LANE_W-1:0] pad_word
);

    // Keep byte k when k < msg_bytes; counts of 8 and above keep the full word.
    always_comb begin
        keep_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < msg_bytes) begin
                keep_mask[8*k +: 8] = 8'hFF;
            end
        end
    end

    // Place the domain pad byte at byte position pad_byte of a lane.
    always_comb begin
        pad_word = '0;
        pad_word[{pad_byte, 3'b000} +: 8] = DOMAIN_PAD;
    end

endmodule

// File: rtl/sha3_absorb.sv
// SHA-3 sponge absorb front end. XORs 64-bit little-endian message words into
// the rate lanes, applies the 0x06..0x80 padding, launches one permutation per
// full rate block through a start/done handshake and presents the final state.
module sha3_absorb
    import sha3_pkg::*;
#(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN_PAD = PAD_DOMAIN
) (
    input  logic          clk,
    input  logic          rst,
    sha3_absorb_if.slave  bus
);

    localparam int             IDX_W     = 5;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATE_LANES - 1);
    localparam logic [IDX_W-1:0] RATE_IDX  = IDX_W'(RATE_LANES);
    // Byte 7 of the last rate lane receives the closing 0x80.
    localparam int             FINAL_POS = (RATE_LANES - 1) * LANE_W + 56;

    absorb_state_t      fsm, fsm_next;
    logic [STATE_W-1:0] st, st_next;
    logic [IDX_W-1:0]   lane_idx, lane_idx_next;
    logic [IDX_W-1:0]   pad_lane, pad_lane_next;
    logic [2:0]         pad_byte, pad_byte_next;
    logic               final_flag, final_next;
    logic               final_pending, pending_next;

    logic [LANE_W-1:0]  keep_mask;
    logic [LANE_W-1:0]  pad_word;
    logic [LANE_W-1:0]  masked_word;
    logic [IDX_W-1:0]   lane_after;

    sha3_byte_mask #(
        .DOMAIN_PAD (DOMAIN_PAD)
    ) u_byte_mask (
        .msg_bytes (bus.msg_bytes),
        .pad_byte  (pad_byte),
        .keep_mask (keep_mask),
        .pad_word  (pad_word)
    );

    // Only the final word is trimmed; earlier words are always full.
    assign masked_word = bus.msg_last ? (bus.msg_data & keep_mask) : bus.msg_data;
    assign lane_after  = lane_idx + IDX_W'(1);

    // The state register doubles as the permutation input and the result, so it
    // must stay untouched between perm_start and perm_done.
    assign bus.perm_state_out = st;
    assign bus.state_out      = st;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Sponge state, lane cursor and padding bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= '0;
            lane_idx      <= '0;
            pad_lane      <= '0;
            pad_byte      <= '0;
            final_flag    <= 1'b0;
            final_pending <= 1'b0;
        end else begin
            st            <= st_next;
            lane_idx      <= lane_idx_next;
            pad_lane      <= pad_lane_next;
            pad_byte      <= pad_byte_next;
            final_flag    <= final_next;
            final_pending <= pending_next;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        fsm_next        = fsm;
        st_next         = st;
        lane_idx_next   = lane_idx;
        pad_lane_next   = pad_lane;
        pad_byte_next   = pad_byte;
        final_next      = final_flag;
        pending_next    = final_pending;
        bus.msg_ready   = 1'b0;
        bus.perm_start  = 1'b0;
        bus.absorb_done = 1'b0;
        bus.busy        = (fsm != IDLE);

        case (fsm)
            IDLE: begin
                if (bus.start) begin
                    st_next       = '0;
                    lane_idx_next = '0;
                    pad_lane_next = '0;
                    pad_byte_next = '0;
                    final_next    = 1'b0;
                    pending_next  = 1'b0;
                    fsm_next      = ABSORB;
                end
            end

            ABSORB: begin
                bus.msg_ready = 1'b1;
                if (bus.msg_valid) begin
                    st_next[lane_lo(lane_idx) +: LANE_W] =
                        st[lane_lo(lane_idx) +: LANE_W] ^ masked_word;
                    if (!bus.msg_last) begin
                        if (lane_idx == LAST_IDX) begin
                            lane_idx_next = '0;
                            fsm_next      = PERM_REQ;
                        end else begin
                            lane_idx_next = lane_after;
                        end
                    end else begin
                        lane_idx_next = '0;
                        if (bus.msg_bytes < 4'd8) begin
                            // Partial word: pad right after the last data byte.
                            pad_lane_next = lane_idx;
                            pad_byte_next = bus.msg_bytes[2:0];
                            fsm_next      = PAD;
                        end else if (lane_after == RATE_IDX) begin
                            // Full word filled the block: padding goes into a
                            // fresh block after this permutation.
                            pad_lane_next = '0;
                            pad_byte_next = '0;
                            pending_next  = 1'b1;
                            fsm_next      = PERM_REQ;
                        end else begin
                            pad_lane_next = lane_after;
                            pad_byte_next = '0;
                            fsm_next      = PAD;
                        end
                    end
                end
            end

            PAD: begin
                // Both XORs accumulate, so a shared byte ends up as 0x06 | 0x80.
                st_next[lane_lo(pad_lane) +: LANE_W] =
                    st_next[lane_lo(pad_lane) +: LANE_W] ^ pad_word;
                st_next[FINAL_POS +: 8] = st_next[FINAL_POS +: 8] ^ PAD_FINAL;
                final_next   = 1'b1;
                pending_next = 1'b0;
                fsm_next     = PERM_REQ;
            end

            PERM_REQ: begin
                bus.perm_start = 1'b1;
                fsm_next       = PERM_WAIT;
            end

            PERM_WAIT: begin
                if (bus.perm_done) begin
                    st_next = bus.perm_state_in;
                    if (final_flag) begin
                        fsm_next = DONE;
                    end else if (final_pending) begin
                        pad_lane_next = '0;
                        pad_byte_next = '0;
                        fsm_next      = PAD;
                    end else begin
                        fsm_next = ABSORB;
                    end
                end
            end

            DONE: begin
                bus.absorb_done = 1'b1;
                fsm_next        = IDLE;
            end

            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sha3_absorb.sv
// Directed bench for sha3_absorb with an identity permutation stub that
// answers perm_start with perm_done three cycles later.
module tb_sha3_absorb;
    import sha3_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha3_absorb_if bus ();

    sha3_absorb #(
        .RATE_LANES (17),
        .DOMAIN_PAD (8'h06)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Identity permutation: echoes the requested state three cycles later.
    logic [2:0]         perm_sr   = '0;
    logic [STATE_W-1:0] perm_held = '0;
    always @(posedge clk) begin
        perm_sr <= {perm_sr[1:0], bus.perm_start};
        if (bus.perm_start) perm_held <= bus.perm_state_out;
    end
    assign bus.perm_done     = perm_sr[2];
    assign bus.perm_state_in = perm_held;

    // Pulse counters and msg_ready watch while a permutation is outstanding.
    int   n_perm = 0, n_done = 0, n_ready_viol = 0;
    logic waiting = 1'b0;
    always @(negedge clk) begin
        if (bus.perm_start)  n_perm <= n_perm + 1;
        if (bus.absorb_done) n_done <= n_done + 1;
        if (waiting && bus.msg_ready) n_ready_viol <= n_ready_viol + 1;
        if (bus.perm_start)      waiting <= 1'b1;
        else if (bus.perm_done)  waiting <= 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_of(input logic [STATE_W-1:0] s, input int i);
        logic [STATE_W-1:0] t;
        t = s >> (i * 64);
        return t[63:0];
    endfunction

    function automatic logic [63:0] word_of(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i * 7)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_msg();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int guard;
        guard = 0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = d;
        bus.msg_last  = last;
        bus.msg_bytes = nb;
        while (!bus.msg_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!bus.msg_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word: msg_ready stayed %0b, expected 1", bus.msg_ready);
        end
        tick();
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
        bus.msg_data  = '0;
        bus.msg_bytes = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.absorb_done && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.absorb_done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: absorb_done stayed 0 for %0d cycles, expected a pulse", lat);
        end
    endtask

    // Lanes 2..24 except 16 must be zero for single-word messages.
    function automatic logic [63:0] other_lanes(input logic [STATE_W-1:0] s, input int from);
        logic [63:0] acc;
        acc = '0;
        for (int i = from; i < NUM_LANES; i++) begin
            if (i != 16) acc = acc | lane_of(s, i);
        end
        return acc;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nbytes;
        logic [63:0] exp0;
        logic [63:0] exp1;
        logic [63:0] exp16;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, p0, d0, v0;
        logic [STATE_W-1:0] snap;

        vecs[0] = '{64'h0000000000000000, 4'd0,  64'h0000000000000006, 64'h0, 64'h8000000000000000};
        vecs[1] = '{64'h0000000000636261, 4'd3,  64'h0000000006636261, 64'h0, 64'h8000000000000000};
        vecs[2] = '{64'hFFFFFFFFFF636261, 4'd3,  64'h0000000006636261, 64'h0, 64'h8000000000000000};
        vecs[3] = '{64'h1122334455667788, 4'd8,  64'h1122334455667788, 64'h6, 64'h8000000000000000};
        vecs[4] = '{64'hAABBCCDDEEFF0011, 4'd7,  64'h06BBCCDDEEFF0011, 64'h0, 64'h8000000000000000};
        vecs[5] = '{64'h0123456789ABCDEF, 4'd12, 64'h0123456789ABCDEF, 64'h6, 64'h8000000000000000};
        vecs[6] = '{64'h123456789ABCDEFF, 4'd1,  64'h00000000000006FF, 64'h0, 64'h8000000000000000};

        bus.start = 1'b0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0;
        bus.msg_data = '0; bus.msg_bytes = '0;
        rst = 1'b1;
        tick(); tick();
        check64("reset busy",        64'(bus.busy), 64'd0);
        check64("reset msg_ready",   64'(bus.msg_ready), 64'd0);
        check64("reset perm_start",  64'(bus.perm_start), 64'd0);
        check64("reset absorb_done", 64'(bus.absorb_done), 64'd0);
        check64("reset state_out",   64'(bus.state_out != '0), 64'd0);
        check64("reset perm_state_out", 64'(bus.perm_state_out != '0), 64'd0);
        rst = 1'b0;
        tick();

        // Single-word messages from the table.
        for (int v = 0; v < 7; v++) begin
            p0 = n_perm; d0 = n_done;
            begin_msg();
            send_word(vecs[v].data, 1'b1, vecs[v].nbytes);
            wait_done(lat);
            check64($sformatf("vec%0d latency", v), 64'(lat), 64'd5);
            check64($sformatf("vec%0d lane0", v),  lane_of(bus.state_out, 0),  vecs[v].exp0);
            check64($sformatf("vec%0d lane1", v),  lane_of(bus.state_out, 1),  vecs[v].exp1);
            check64($sformatf("vec%0d lane16", v), lane_of(bus.state_out, 16), vecs[v].exp16);
            check64($sformatf("vec%0d other lanes", v), other_lanes(bus.state_out, 2), 64'h0);
            tick(); tick();
            check64($sformatf("vec%0d perm_start pulses", v), 64'(n_perm - p0), 64'd1);
            check64($sformatf("vec%0d absorb_done pulses", v), 64'(n_done - d0), 64'd1);
            check64($sformatf("vec%0d busy after", v), 64'(bus.busy), 64'd0);
        end

        // 16 full words: padding shares lane 16 with the closing 0x80.
        p0 = n_perm;
        begin_msg();
        for (int i = 0; i < 16; i++) send_word(word_of(i), (i == 15), 4'd8);
        wait_done(lat);
        for (int i = 0; i < 16; i++)
            check64($sformatf("w16 lane%0d", i), lane_of(bus.state_out, i), word_of(i));
        check64("w16 lane16", lane_of(bus.state_out, 16), 64'h8000000000000006);
        check64("w16 capacity", other_lanes(bus.state_out, 17), 64'h0);
        tick(); tick();
        check64("w16 perm_start pulses", 64'(n_perm - p0), 64'd1);

        // 17 full words: block fills, padding lands in a second block.
        p0 = n_perm; v0 = n_ready_viol;
        begin_msg();
        for (int i = 0; i < 17; i++) send_word(word_of(i), (i == 16), 4'd8);
        wait_done(lat);
        check64("w17 latency", 64'(lat), 64'd9);
        check64("w17 lane0", lane_of(bus.state_out, 0), word_of(0) ^ 64'h06);
        for (int i = 1; i < 16; i++)
            check64($sformatf("w17 lane%0d", i), lane_of(bus.state_out, i), word_of(i));
        check64("w17 lane16", lane_of(bus.state_out, 16), word_of(16) ^ 64'h8000000000000000);
        check64("w17 capacity", other_lanes(bus.state_out, 17), 64'h0);
        tick(); tick();
        check64("w17 perm_start pulses", 64'(n_perm - p0), 64'd2);
        check64("w17 msg_ready during wait", 64'(n_ready_viol - v0), 64'd0);

        // Reset during PERM_WAIT, then the stale perm_done must be ignored.
        d0 = n_done;
        begin_msg();
        send_word(64'h0, 1'b1, 4'd0);
        tick();            // PERM_REQ
        tick();            // PERM_WAIT
        snap = bus.state_out;
        check64("pre-reset state nonzero", 64'(snap != '0), 64'd1);
        rst = 1'b1;
        #1;
        check64("mid rst busy",      64'(bus.busy), 64'd0);
        check64("mid rst state_out", 64'(bus.state_out != '0), 64'd0);
        check64("mid rst perm_state_out", 64'(bus.perm_state_out != '0), 64'd0);
        tick();
        rst = 1'b0;
        p0 = n_perm;
        tick(); tick(); tick();
        check64("stale done busy",        64'(bus.busy), 64'd0);
        check64("stale done msg_ready",   64'(bus.msg_ready), 64'd0);
        check64("stale done state_out",   64'(bus.state_out != '0), 64'd0);
        check64("stale done absorb_done", 64'(n_done - d0), 64'd0);
        check64("stale done perm_start",  64'(n_perm - p0), 64'd0);

        // Empty message after the reset reproduces the plain empty result.
        begin_msg();
        send_word(64'h0, 1'b1, 4'd0);
        wait_done(lat);
        check64("post rst lane0",  lane_of(bus.state_out, 0),  64'h06);
        check64("post rst lane16", lane_of(bus.state_out, 16), 64'h8000000000000000);
        check64("post rst others", other_lanes(bus.state_out, 1), 64'h0);
        tick(); tick();
        check64("post rst absorb_done", 64'(n_done - d0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a stimulus task misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, expected finish", $time);
        $fatal(1);
    end

endmodule
